// File: rtl/ro_freq_counter.sv
// Gated ring-oscillator frequency counter: prescaled RO edges counted over a wb_clk_i window.
// Latency: start accepted at t -> ARM t+1 -> GATE t+2..t+1+G -> valid_o from t+2+G (t+1 when G=0).
// Backpressure: result/valid/overflow held in DONE until ready_i; start_i ignored while not IDLE.
module ro_freq_counter #(
    parameter int PRESCALE_BITS = 4,
    parameter int GATE_W        = 16,
    parameter int CNT_W         = 24
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              ro_in,
    input  logic              start_i,
    input  logic [GATE_W-1:0] gate_cycles_i,
    output logic              busy_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  result_o,
    output logic              overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                   r_state;
    state_t                   w_next;
    logic [PRESCALE_BITS-1:0] r_presc;
    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_hist;
    logic                     w_edge;
    logic [GATE_W-1:0]        r_gate;
    logic [CNT_W-1:0]         r_count;
    logic [CNT_W-1:0]         w_count_nxt;
    logic [CNT_W-1:0]         r_result;
    logic                     r_ovf;
    logic                     w_start;
    logic                     w_gate_zero;
    logic                     w_gate_last;
    logic                     w_sat_hit;

    // Free-running prescaler in the oscillator domain; only its MSB leaves this domain.
    always_ff @(posedge ro_in or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESCALE_BITS'(1);
        end
    end

    // Two-flop synchroniser for the prescaler MSB plus a history flop for edge detection.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= r_presc[PRESCALE_BITS-1];
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_edge      = r_sync2 & ~r_hist;
    assign w_start     = (r_state == S_IDLE) && start_i;
    assign w_gate_zero = (gate_cycles_i == '0);
    assign w_gate_last = (r_gate == GATE_W'(1));
    // Count saturates at all-ones; an edge arriving there flags overflow instead of wrapping.
    assign w_sat_hit   = w_edge && (r_count == CNT_MAX);
    assign w_count_nxt = (w_edge && !w_sat_hit) ? (r_count + CNT_W'(1)) : r_count;

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = w_gate_zero ? S_DONE : S_ARM;
                end
            end
            S_ARM:  w_next = S_GATE;
            S_GATE: begin
                if (w_gate_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Gate counter, edge count, overflow flag and held result.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_gate   <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (w_start) begin
            r_gate  <= gate_cycles_i;
            r_count <= '0;
            r_ovf   <= 1'b0;
            if (w_gate_zero) begin
                r_result <= '0;
            end
        end else if (r_state == S_GATE) begin
            // Edges seen in ARM are dropped; the final GATE cycle's edge still counts.
            r_gate  <= r_gate - GATE_W'(1);
            r_count <= w_count_nxt;
            if (w_sat_hit) begin
                r_ovf <= 1'b1;
            end
            if (w_gate_last) begin
                r_result <= w_count_nxt;
            end
        end
    end

    assign busy_o     = (r_state == S_ARM) || (r_state == S_GATE);
    assign valid_o    = (r_state == S_DONE);
    assign result_o   = r_result;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: two instances (default and 4-bit count) driven identically.
// Expected counts come from the oscillator/clock period ratio with +-1 edge tolerance.
// A negedge monitor pops the expectation queues whenever valid_o rises.
module tb_ro_freq_counter;
    localparam int GW     = 16;
    localparam int CW     = 24;
    localparam int SW     = 4;
    localparam int CLK_PS = 10000;

    typedef struct {
        int     cyc;
        longint lo;
        longint hi;
        int     ovf;   // 2 = either value acceptable
        int     busy;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ro_in = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [GW-1:0] gate  = '0;
    logic          busy_m, valid_m, ovf_m;
    logic [CW-1:0] res_m;
    logic          busy_s, valid_s, ovf_s;
    logic [SW-1:0] res_s;

    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   ro_half = 1250;
    int   ro_per  = 2500;
    bit   ro_en   = 1'b1;
    exp_t q_m[$];
    exp_t q_s[$];

    ro_freq_counter u_main (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .ro_in(ro_in), .start_i(start),
        .gate_cycles_i(gate), .busy_o(busy_m), .valid_o(valid_m), .ready_i(ready),
        .result_o(res_m), .overflow_o(ovf_m)
    );

    ro_freq_counter #(.CNT_W(SW)) u_sat (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .ro_in(ro_in), .start_i(start),
        .gate_cycles_i(gate), .busy_o(busy_s), .valid_o(valid_s), .ready_i(ready),
        .result_o(res_s), .overflow_o(ovf_s)
    );

    always #5000 clk = ~clk;

    always begin
        #(ro_half);
        if (ro_en) ro_in = ~ro_in;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(1000000000);
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint lo, input longint hi);
        vectors++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    function automatic exp_t clamp_exp(input exp_t e, input longint mx);
        exp_t r = e;
        if (e.lo > mx)       r.ovf = 1;
        else if (e.hi <= mx) r.ovf = 0;
        else                 r.ovf = 2;
        if (r.lo > mx) r.lo = mx;
        if (r.hi > mx) r.hi = mx;
        return r;
    endfunction

    // Reference: a G-cycle window sees G*Tclk/(16*Tro) prescaled edges, +-1 for phase.
    task automatic push_exp(input int g);
        exp_t   e;
        longint num, den;
        if (g == 0 || !ro_en) begin
            e.lo = 0;
            e.hi = 0;
        end else begin
            num  = longint'(g) * CLK_PS;
            den  = 16 * longint'(ro_per);
            e.lo = num / den - 1;
            if (e.lo < 0) e.lo = 0;
            e.hi = (num + den - 1) / den + 1;
        end
        e.cyc  = cyc + ((g == 0) ? 1 : g + 2);
        e.busy = (g == 0) ? 0 : g + 1;
        e.ovf  = 0;
        q_m.push_back(clamp_exp(e, (longint'(1) << CW) - 1));
        q_s.push_back(clamp_exp(e, (longint'(1) << SW) - 1));
    endtask

    task automatic mon_pop(input int inst, input longint res, input int ovf, input int bc);
        exp_t  e;
        string tag;
        tag = (inst == 0) ? "main" : "sat";
        if ((inst == 0 && q_m.size() == 0) || (inst == 1 && q_s.size() == 0)) begin
            vectors++;
            fails++;
            $display("FAIL unexpected_valid_%s: got valid with result %0d, want no valid", tag, res);
            return;
        end
        e = (inst == 0) ? q_m.pop_front() : q_s.pop_front();
        check({"latency_", tag}, cyc, e.cyc, e.cyc);
        check({"result_", tag}, res, e.lo, e.hi);
        if (e.ovf != 2) check({"overflow_", tag}, ovf, e.ovf, e.ovf);
        check({"busy_cycles_", tag}, bc, e.busy, e.busy);
    endtask

    // Monitor: compare every new result against the scoreboard.
    bit pv_m = 0, pv_s = 0;
    int bc_m = 0, bc_s = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_m = 0; pv_s = 0; bc_m = 0; bc_s = 0;
        end else begin
            if (busy_m) bc_m++;
            if (busy_s) bc_s++;
            if (valid_m && !pv_m) begin
                mon_pop(0, longint'(res_m), int'(ovf_m), bc_m);
                bc_m = 0;
            end
            if (valid_s && !pv_s) begin
                mon_pop(1, longint'(res_s), int'(ovf_s), bc_s);
                bc_s = 0;
            end
            pv_m = valid_m;
            pv_s = valid_s;
        end
    end

    task automatic set_ro(input int per, input bit en);
        ro_per  = per;
        ro_half = per / 2;
        ro_en   = en;
        repeat (40) @(negedge clk);
    endtask

    // One measurement: start, wait for valid, hold ready low rdly cycles, then accept.
    task automatic run_meas(input int g, input int rdly, input bit poke);
        int          n;
        logic [CW-1:0] r0;
        push_exp(g);
        gate  = GW'(g);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!valid_m && n < g + 20) begin
            @(negedge clk);
            n++;
        end
        if (!valid_m) begin
            check("valid_timeout", 0, 1, 1);
            return;
        end
        r0 = res_m;
        for (int i = 0; i < rdly; i++) begin
            start = poke && (i == 2);
            gate  = GW'(7);
            @(negedge clk);
            start = 1'b0;
            check("hold_valid", valid_m, 1, 1);
            check("hold_result", res_m, r0, r0);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("valid_drop", valid_m, 0, 0);
        check("idle_after", busy_m, 0, 0);
    endtask

    initial begin
        // Reset with the oscillator running.
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_busy_m", busy_m, 0, 0);
        check("rst_valid_m", valid_m, 0, 0);
        check("rst_result_m", res_m, 0, 0);
        check("rst_ovf_m", ovf_m, 0, 0);
        check("rst_busy_s", busy_s, 0, 0);
        check("rst_valid_s", valid_s, 0, 0);
        check("rst_result_s", res_s, 0, 0);
        check("rst_ovf_s", ovf_s, 0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_valid", valid_m, 0, 0);
        check("post_rst_busy", busy_m, 0, 0);

        // Nominal: f_ro = 4*f_clk, 1000-cycle gate (also saturates the 4-bit instance).
        set_ro(2500, 1'b1);
        run_meas(1000, 0, 0);
        // Handshake hold with an ignored start while DONE.
        run_meas(50, 20, 1);
        // Zero gate.
        run_meas(0, 3, 0);
        // One-cycle gate with oscillator stopped.
        set_ro(2500, 1'b0);
        run_meas(1, 0, 0);
        // Saturation then clear on next start.
        set_ro(2500, 1'b1);
        run_meas(200, 0, 0);
        run_meas(4, 0, 0);
        run_meas(300, 0, 0);

        // Mid-operation reset.
        gate  = GW'(500);
        start = 1'b1;
        q_m.push_back('{0, 0, 0, 0, 0});
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst_busy_before", busy_m, 1, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy_m", busy_m, 0, 0);
        check("midrst_result_m", res_m, 0, 0);
        check("midrst_valid_m", valid_m, 0, 0);
        check("midrst_busy_s", busy_s, 0, 0);
        check("midrst_result_s", res_s, 0, 0);
        q_m.delete();
        q_s.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_meas(400, 2, 0);

        // Randomised measurements.
        for (int k = 0; k < 12; k++) begin
            int  per, g, rd;
            bit  stop;
            per  = 2 * $urandom_range(1000, 10000);
            stop = ($urandom_range(0, 5) == 0);
            g    = $urandom_range(0, 600);
            rd   = $urandom_range(0, 4);
            set_ro(per, !stop);
            run_meas(g, rd, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("queue_main_empty", q_m.size(), 0, 0);
        check("queue_sat_empty", q_s.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Gated frequency counter that sits directly downstream of the ring-oscillator select mux.
- It consumes the selected oscillator output on io_out[0] and divides it with a prescaler clocked by the oscillator itself.
- The prescaler MSB is synchronised into the wb_clk_i domain, and its rising edges are counted over a programmable window of wb_clk_i cycles.
- Each result is presented with a valid/ready handshake for readout logic, such as a later Wishbone register bank.

Parameters:
- PRESCALE_BITS, 4, width of the ro_in-domain prescaler; each counted edge equals 2^PRESCALE_BITS oscillator periods.
- GATE_W, 16, width of the gate-length input in wb_clk_i cycles.
- CNT_W, 24, width of the result counter.

Ports:
- wb_clk_i  input  1  system clock; all control logic runs on it.
- wb_rst_n_i  input  1  asynchronous active-low reset; one clock; the polarity and synchronicity are fixed. It also resets the prescaler.
- ro_in  input  1  selected ring-oscillator output, asynchronous to wb_clk_i.
- start_i  input  1  one-cycle request to begin a measurement.
- gate_cycles_i  input  GATE_W  measurement window length, sampled on an accepted start.
- busy_o  output  1  high while in ARM or GATE.
- valid_o  output  1  result available.
- ready_i  input  1  consumer accepts the result.
- result_o  output  CNT_W  prescaled edge count.
- overflow_o  output  1  the count saturated during this measurement.

Behaviour:
- Reset values: busy_o=0, valid_o=0, result_o=0, overflow_o=0, FSM=IDLE. All synchroniser flops and the prescaler reset to 0.
- Prescaler:
  - PRESCALE_BITS-bit up-counter clocked on the ro_in rising edge.
  - Free-running, wraps at 2^PRESCALE_BITS-1 -> 0, asynchronously cleared by wb_rst_n_i.
  - Its MSB (pmsb) is the only signal that crosses into the wb_clk_i domain.
- CDC:
  - pmsb passes through a 2-flop synchroniser plus one history flop.
  - edge = sync & ~hist, at most one edge per wb_clk_i cycle.
  - Valid operation requires f_ro < 2^(PRESCALE_BITS-1) * f_wb_clk_i; above that the result is undefined but the FSM still completes.
- FSM states and transitions:
  - IDLE: start_i=1 -> latch gate_cycles_i into the gate counter, clear the count and overflow, go to ARM. If the latched value is 0, go straight to DONE with result_o=0.
  - ARM: one cycle. Discards any edge detected in this cycle, then -> GATE.
  - GATE: the gate counter decrements each cycle and each edge increments count. When the gate counter reaches 1, that cycle's edge is still counted, then -> DONE. GATE therefore lasts exactly gate_cycles_i cycles.
  - DONE: result_o=count, valid_o=1. result_o, valid_o and overflow_o hold stable until ready_i=1, then -> IDLE with valid_o=0 the next cycle. result_o keeps its last value in IDLE.
- Latency: start accepted at cycle t -> ARM at t+1 -> GATE over t+2..t+1+G -> valid_o high from t+2+G.
- ready_i=1 in the first DONE cycle completes the handshake in that cycle, so valid_o is high for one cycle.
- start_i is ignored in ARM, GATE and DONE; there is no queuing. start_i and ready_i together in DONE: only ready_i acts.
- Saturation: when count=2^CNT_W-1, further edges do not wrap; overflow_o is set and holds until the next accepted start.
- Reset mid-operation: an immediate asynchronous return to reset values; any partial count is discarded.
- Measurement resolution is ±1 edge, due to the unknown prescaler phase at gate start.

Test Plan:
- Reset: hold wb_rst_n_i=0 with ro_in toggling -> all outputs 0, FSM in IDLE. Release -> still idle, no valid_o.
- Nominal, with the oscillator modelled at f_ro = 4*f_clk and PRESCALE_BITS=4: gate_cycles_i=1000, start_i pulse -> valid_o rises exactly 1002 cycles after start. result_o in 249..251. busy_o high for 1001 cycles.
- Handshake hold: ready_i=0 for 20 cycles after valid_o -> result_o and valid_o stable. A start_i pulse during this time is ignored. ready_i=1 -> valid_o drops next cycle.
- Zero and short gates:
  - gate_cycles_i=0 -> valid_o the cycle after start, result_o=0.
  - gate_cycles_i=1 with ro_in stopped -> result_o=0, valid_o at t+3.
- Saturation, with CNT_W=4 and f_ro = 4*f_clk: gate_cycles_i=200 -> result_o=15, overflow_o=1. The next start with gate_cycles_i=4 clears overflow_o.
- Mid-operation reset: assert wb_rst_n_i during GATE -> busy_o=0, result_o=0 immediately. A new start afterwards completes normally with the correct count.
